// File: rtl/weight_bank_loader.sv
// Purpose    : writer side of the weight-bank select path; packs a stream of weight
//              words into a SEL_SIZE-slot bank that is presented as one flat bus.
// Latency    : an accepted word is visible on o_Bank the cycle after its handshake;
//              o_Done pulses the cycle after the final word of the load is accepted.
// Backpressure: o_InReady is high for every LOAD cycle and low otherwise; words are
//              only taken when i_InValid && o_InReady, so the source may insert bubbles.
//
// Ports:
//   i_Clk / i_Reset_n          : rising-edge clock, asynchronous active-low reset
//   i_Start/i_StartSel/i_NumSlots : load request (first slot, slot count), IDLE only
//   i_Abort                    : cancel a load in progress
//   i_InValid/i_InData/o_InReady : weight-word stream handshake
//   o_Bank                     : packed bank, slot k at [OUT_SIZE*(k+1)-1 : OUT_SIZE*k]
//   o_SlotValid                : per-slot fully-loaded flags
//   o_Busy / o_Done / o_Error  : in LOAD / load-complete pulse / rejected-Start pulse
//
// OUT_SIZE must equal WORD_SIZE*WORDS_PER_SLOT and 2**SEL_BIT must be >= SEL_SIZE.
module weight_bank_loader #(
    parameter int WORD_SIZE      = 19,
    parameter int WORDS_PER_SLOT = 28,
    parameter int OUT_SIZE       = 532,
    parameter int SEL_SIZE       = 28,
    parameter int SEL_BIT        = 5
) (
    input  logic                         i_Clk,
    input  logic                         i_Reset_n,
    input  logic                         i_Start,
    input  logic [SEL_BIT-1:0]           i_StartSel,
    input  logic [SEL_BIT-1:0]           i_NumSlots,
    input  logic                         i_Abort,
    input  logic                         i_InValid,
    input  logic [WORD_SIZE-1:0]         i_InData,
    output logic                         o_InReady,
    output logic [OUT_SIZE*SEL_SIZE-1:0] o_Bank,
    output logic [SEL_SIZE-1:0]          o_SlotValid,
    output logic                         o_Busy,
    output logic                         o_Done,
    output logic                         o_Error
);

    localparam int BANK_W = OUT_SIZE * SEL_SIZE;
    localparam int IDX_W  = $clog2(BANK_W);
    localparam int WORD_W = (WORDS_PER_SLOT > 1) ? $clog2(WORDS_PER_SLOT) : 1;
    localparam logic [WORD_W-1:0] LAST_WORD = WORD_W'(WORDS_PER_SLOT - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t              r_state;
    logic [SEL_BIT-1:0]  r_slot;
    logic [SEL_BIT-1:0]  r_end;
    logic [WORD_W-1:0]   r_word;
    logic [BANK_W-1:0]   r_bank;
    logic [SEL_SIZE-1:0] r_slot_valid;
    logic                r_in_ready;
    logic                r_busy;
    logic                r_done;
    logic                r_error;

    logic [SEL_BIT:0]    w_range_sum;
    logic                w_start_ok;
    logic [SEL_BIT-1:0]  w_end;
    logic [SEL_SIZE-1:0] w_clr_mask;
    logic                w_accept;
    logic                w_last_word;
    logic                w_last_slot;
    logic [IDX_W-1:0]    w_wr_base;

    // One extra bit on the sum so StartSel+NumSlots cannot wrap past SEL_SIZE.
    assign w_range_sum = {1'b0, i_StartSel} + {1'b0, i_NumSlots};
    assign w_start_ok  = (i_NumSlots != '0) && (w_range_sum <= (SEL_BIT+1)'(SEL_SIZE));
    // Only meaningful when w_start_ok; the sum is then in 1..SEL_SIZE so the
    // low bits minus one give the last slot even when SEL_SIZE == 2**SEL_BIT.
    assign w_end       = w_range_sum[SEL_BIT-1:0] - SEL_BIT'(1);

    // Slots StartSel..end lose their valid flag as soon as the load is accepted.
    always_comb begin
        w_clr_mask = '0;
        for (int i = 0; i < SEL_SIZE; i++) begin
            w_clr_mask[i] = (SEL_BIT'(i) >= i_StartSel) && (SEL_BIT'(i) <= w_end);
        end
    end

    // Abort wins over a word presented in the same cycle.
    assign w_accept    = (r_state == S_LOAD) && r_in_ready && i_InValid && !i_Abort;
    assign w_last_word = (r_word == LAST_WORD);
    assign w_last_slot = (r_slot == r_end);
    assign w_wr_base   = IDX_W'(r_slot) * IDX_W'(OUT_SIZE) + IDX_W'(r_word) * IDX_W'(WORD_SIZE);

    always_ff @(posedge i_Clk or negedge i_Reset_n) begin
        if (!i_Reset_n) begin
            r_state      <= S_IDLE;
            r_slot       <= '0;
            r_end        <= '0;
            r_word       <= '0;
            r_bank       <= '0;
            r_slot_valid <= '0;
            r_in_ready   <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_error      <= 1'b0;
        end else begin
            // Done and Error are single-cycle pulses unless re-armed below.
            r_done  <= 1'b0;
            r_error <= 1'b0;

            case (r_state)
                S_IDLE: begin
                    if (i_Start) begin
                        if (w_start_ok) begin
                            r_state      <= S_LOAD;
                            r_slot       <= i_StartSel;
                            r_end        <= w_end;
                            r_word       <= '0;
                            r_slot_valid <= r_slot_valid & ~w_clr_mask;
                            r_in_ready   <= 1'b1;
                            r_busy       <= 1'b1;
                        end else begin
                            r_error <= 1'b1;
                        end
                    end
                end

                S_LOAD: begin
                    if (i_Abort) begin
                        // Words already written stay; the partial slot stays invalid.
                        r_state    <= S_IDLE;
                        r_word     <= '0;
                        r_in_ready <= 1'b0;
                        r_busy     <= 1'b0;
                    end else if (w_accept) begin
                        r_bank[w_wr_base +: WORD_SIZE] <= i_InData;
                        if (w_last_word) begin
                            r_word               <= '0;
                            r_slot_valid[r_slot] <= 1'b1;
                            if (w_last_slot) begin
                                r_state    <= S_DONE;
                                r_in_ready <= 1'b0;
                                r_busy     <= 1'b0;
                                r_done     <= 1'b1;
                            end else begin
                                r_slot <= r_slot + SEL_BIT'(1);
                            end
                        end else begin
                            r_word <= r_word + WORD_W'(1);
                        end
                    end
                end

                S_DONE: begin
                    r_state <= S_IDLE;
                end

                default: begin
                    r_state    <= S_IDLE;
                    r_in_ready <= 1'b0;
                    r_busy     <= 1'b0;
                end
            endcase
        end
    end

    assign o_InReady   = r_in_ready;
    assign o_Bank      = r_bank;
    assign o_SlotValid = r_slot_valid;
    assign o_Busy      = r_busy;
    assign o_Done      = r_done;
    assign o_Error     = r_error;

endmodule

// File: tb/tb_weight_bank_loader.sv
// Purpose    : self-checking bench for weight_bank_loader against a word-array model.
// Latency    : model expectations are set just after each rising edge, checked on the falling edge.
// Backpressure: stimulus inserts pseudo-random InValid bubbles during long loads.
module tb_weight_bank_loader;

    localparam int WS   = 19;
    localparam int WPS  = 28;
    localparam int OS   = 532;
    localparam int SS   = 28;
    localparam int SB   = 5;
    localparam int BW   = OS * SS;

    logic          clk;
    logic          rst_n;
    logic          i_start;
    logic [SB-1:0] i_start_sel;
    logic [SB-1:0] i_num_slots;
    logic          i_abort;
    logic          i_in_vld;
    logic [WS-1:0] i_in_dat;
    logic          o_in_rdy;
    logic [BW-1:0] o_bank;
    logic [SS-1:0] o_slot_valid;
    logic          o_busy;
    logic          o_done;
    logic          o_error;

    weight_bank_loader #(
        .WORD_SIZE(WS), .WORDS_PER_SLOT(WPS), .OUT_SIZE(OS), .SEL_SIZE(SS), .SEL_BIT(SB)
    ) dut (
        .i_Clk(clk), .i_Reset_n(rst_n), .i_Start(i_start), .i_StartSel(i_start_sel),
        .i_NumSlots(i_num_slots), .i_Abort(i_abort), .i_InValid(i_in_vld),
        .i_InData(i_in_dat), .o_InReady(o_in_rdy), .o_Bank(o_bank),
        .o_SlotValid(o_slot_valid), .o_Busy(o_busy), .o_Done(o_done), .o_Error(o_error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model: the bank as a 2-D array of words plus the expected control outputs.
    logic [WS-1:0] exp_words [SS][WPS];
    logic [SS-1:0] exp_sv;
    logic          exp_rdy, exp_busy, exp_done, exp_err;
    logic          chk_en;
    int            n_cmp, n_bad, n_done;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
        n_cmp++;
        if (act !== expv) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", name, act, expv);
        end
    endtask

    function automatic logic [BW-1:0] model_bank();
        logic [BW-1:0] b;
        b = '0;
        for (int s = 0; s < SS; s++)
            for (int w = 0; w < WPS; w++)
                b[s*OS + w*WS +: WS] = exp_words[s][w];
        return b;
    endfunction

    function automatic logic [WS-1:0] wval(input int mode, input int s, input int w);
        case (mode)
            0:       return WS'(w + 1);
            1:       return WS'(s * WPS + w);
            default: return WS'(1000 + s * WPS + w);
        endcase
    endfunction

    task automatic clear_model();
        for (int s = 0; s < SS; s++)
            for (int w = 0; w < WPS; w++)
                exp_words[s][w] = '0;
        exp_sv   = '0;
        exp_rdy  = 1'b0;
        exp_busy = 1'b0;
        exp_done = 1'b0;
        exp_err  = 1'b0;
    endtask

    // Per-cycle comparison of every output against the model.
    always @(negedge clk) begin
        if (o_done === 1'b1) n_done++;
        if (chk_en) begin
            logic [BW-1:0] eb;
            bit            found;
            eb = model_bank();
            n_cmp++;
            if (o_bank !== eb) begin
                n_bad++;
                found = 1'b0;
                for (int s = 0; s < SS; s++)
                    for (int w = 0; w < WPS; w++)
                        if (!found && o_bank[s*OS + w*WS +: WS] !== exp_words[s][w]) begin
                            found = 1'b1;
                            $display("FAIL bank slot %0d word %0d: got %0h want %0h",
                                     s, w, o_bank[s*OS + w*WS +: WS], exp_words[s][w]);
                        end
            end
            chk("slot_valid", 64'(o_slot_valid), 64'(exp_sv));
            chk("in_ready",   64'(o_in_rdy),     64'(exp_rdy));
            chk("busy",       64'(o_busy),       64'(exp_busy));
            chk("done",       64'(o_done),       64'(exp_done));
            chk("error",      64'(o_error),      64'(exp_err));
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
        exp_done = 1'b0;
        exp_err  = 1'b0;
    endtask

    task automatic reject(input int sel, input int n);
        i_start     = 1'b1;
        i_start_sel = SB'(sel);
        i_num_slots = SB'(n);
        step();
        i_start = 1'b0;
        exp_err = 1'b1;
        step();
    endtask

    // stop_kind 0: Abort when stop_at words have been accepted; 1: reset instead.
    task automatic do_load(input int sel, input int n, input int mode, input int bub,
                           input int stop_at, input int stop_kind);
        int            cnt;
        logic [WS-1:0] v;
        i_start     = 1'b1;
        i_start_sel = SB'(sel);
        i_num_slots = SB'(n);
        step();
        i_start  = 1'b0;
        i_abort  = 1'b0;
        exp_rdy  = 1'b1;
        exp_busy = 1'b1;
        for (int s = sel; s < sel + n; s++) exp_sv[s] = 1'b0;
        cnt = 0;
        for (int s = sel; s < sel + n; s++) begin
            for (int w = 0; w < WPS; w++) begin
                if (cnt == stop_at) begin
                    if (stop_kind == 0) begin
                        i_abort  = 1'b1;
                        i_in_vld = 1'b1;
                        i_in_dat = '1;
                        step();
                        i_abort  = 1'b0;
                        i_in_vld = 1'b0;
                        exp_rdy  = 1'b0;
                        exp_busy = 1'b0;
                    end else begin
                        chk_en = 1'b0;
                        #2;
                        rst_n = 1'b0;
                        #1;
                        chk("midrst_bank_zero", 64'(o_bank != '0), 64'(0));
                        chk("midrst_slot_valid", 64'(o_slot_valid), 64'(0));
                        chk("midrst_in_ready", 64'(o_in_rdy), 64'(0));
                        chk("midrst_busy", 64'(o_busy), 64'(0));
                        clear_model();
                        i_in_vld = 1'b0;
                        @(posedge clk);
                        #1;
                        rst_n  = 1'b1;
                        chk_en = 1'b1;
                    end
                    return;
                end
                while ($urandom_range(99) < bub) begin
                    i_in_vld = 1'b0;
                    i_in_dat = WS'($urandom);
                    step();
                end
                v        = wval(mode, s, w);
                i_in_vld = 1'b1;
                i_in_dat = v;
                step();
                exp_words[s][w] = v;
                cnt++;
                if (w == WPS - 1) begin
                    exp_sv[s] = 1'b1;
                    if (s == sel + n - 1) begin
                        exp_rdy  = 1'b0;
                        exp_busy = 1'b0;
                        exp_done = 1'b1;
                    end
                end
            end
        end
        i_in_vld = 1'b0;
        step();
    endtask

    initial begin
        int nd0;
        n_cmp = 0; n_bad = 0; n_done = 0;
        chk_en = 1'b0;
        rst_n = 1'b1;
        i_start = 1'b0; i_start_sel = '0; i_num_slots = '0;
        i_abort = 1'b0; i_in_vld = 1'b0; i_in_dat = '0;
        clear_model();

        // Asynchronous reset asserted mid-cycle, before any clock edge.
        #3 rst_n = 1'b0;
        #1;
        chk("rst_bank_zero", 64'(o_bank != '0), 64'(0));
        chk("rst_slot_valid", 64'(o_slot_valid), 64'(0));
        chk("rst_in_ready", 64'(o_in_rdy), 64'(0));
        chk("rst_busy", 64'(o_busy), 64'(0));
        chk("rst_done", 64'(o_done), 64'(0));
        chk("rst_error", 64'(o_error), 64'(0));
        @(posedge clk);
        @(posedge clk);
        #1 rst_n = 1'b1;
        chk_en = 1'b1;
        step();
        step();

        // Single slot 0, words 1..28 back to back.
        nd0 = n_done;
        do_load(0, 1, 0, 0, -1, 0);
        chk("single_w0", 64'(o_bank[18:0]), 64'd1);
        chk("single_w27", 64'(o_bank[531:513]), 64'd28);
        chk("single_sv", 64'(o_slot_valid), 64'h1);
        chk("single_rest_zero", 64'(o_bank[BW-1:532] != '0), 64'(0));
        chk("single_done_cnt", 64'(n_done - nd0), 64'd1);

        // Whole bank with bubbles.
        nd0 = n_done;
        do_load(0, 28, 1, 30, -1, 0);
        chk("full_sv", 64'(o_slot_valid), 64'hFFFFFFF);
        chk("full_done_cnt", 64'(n_done - nd0), 64'd1);
        chk("full_s27w27", 64'(o_bank[27*OS + 27*WS +: WS]), 64'd783);
        chk("full_s13w5", 64'(o_bank[13*OS + 5*WS +: WS]), 64'd369);

        // Rejected Starts: range overflow, then zero slots.
        reject(27, 2);
        reject(27, 0);
        chk("reject_sv", 64'(o_slot_valid), 64'hFFFFFFF);

        // Abort slot 5 after 10 words.
        nd0 = n_done;
        do_load(5, 1, 2, 0, 10, 0);
        step();
        chk("abort_sv5", 64'(o_slot_valid[5]), 64'd0);
        chk("abort_s5w9", 64'(o_bank[5*OS + 9*WS +: WS]), 64'd1149);
        chk("abort_s5w10", 64'(o_bank[5*OS + 10*WS +: WS]), 64'd150);
        chk("abort_no_done", 64'(n_done - nd0), 64'd0);

        // Reload slot 5 with Abort held alongside Start (Start wins in IDLE).
        i_abort = 1'b1;
        do_load(5, 1, 2, 0, -1, 0);
        chk("reload_sv", 64'(o_slot_valid), 64'hFFFFFFF);
        chk("reload_s5w10", 64'(o_bank[5*OS + 10*WS +: WS]), 64'd1150);

        // Reset after slot 3 of a 6-slot load, then a fresh load.
        do_load(10, 6, 1, 0, 3 * WPS, 1);
        step();
        do_load(10, 2, 1, 10, -1, 0);
        chk("post_rst_sv", 64'(o_slot_valid), 64'hC00);
        chk("post_rst_s11w27", 64'(o_bank[11*OS + 27*WS +: WS]), 64'd335);

        step();
        step();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
